// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input reorder path.
package fft_pkg;

  // Widest frame index the generic bit reverser supports.
  localparam int MAX_LOG2N = 16;

  typedef enum logic {
    MODE_BITREV = 1'b0,
    MODE_BYPASS = 1'b1
  } reorder_mode_t;

  // Reverse the low n bits of a; bits at and above n come back as zero.
  // Shifting a bit in at the LSB per step keeps every index constant.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] a,
                                                  input int unsigned n);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] t;
    r = '0;
    t = a;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < n) begin
        r = {r[MAX_LOG2N-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_addr.sv
// Combinational LOG2N-bit address reverser used on the write path.
module bit_reverse_addr
  import fft_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic [LOG2N-1:0] addr,
  output logic [LOG2N-1:0] rev
);

  assign rev = LOG2N'(bitrev(MAX_LOG2N'(addr), LOG2N));

endmodule

// File: rtl/fft_bitrev_stream.sv
// Streaming bit-reversal reorder buffer with ping-pong frame banks.
//
// Handshake: on both streams a beat transfers on a rising edge where
// valid && ready. The source holds valid and payload stable until that edge;
// ready may change freely. Here s_ready depends only on registered state, and
// m_valid/m_data/m_last depend only on registered state and memory, so
// neither output stream has a combinational path from its own inputs.
module fft_bitrev_stream
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             frame_err
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE = LOG2N'(1);

  logic [WIDTH-1:0] mem [2][N];

  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [1:0]       full;
  reorder_mode_t    mode_q [2];
  logic             frame_err_q;

  logic             s_accept;
  logic             m_accept;
  logic             wr_last;
  logic             rd_last;
  reorder_mode_t    mode_eff;
  logic [LOG2N-1:0] wr_rev;
  logic [LOG2N-1:0] wr_addr;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;

  // A bank still being written is never full, so the write side only stalls
  // when the bank it is about to fill has not drained yet.
  assign s_ready  = !full[wr_bank];
  assign s_accept = s_valid && s_ready;
  assign wr_last  = (wr_cnt == CNT_MAX);

  assign m_valid  = full[rd_bank];
  assign m_accept = m_valid && m_ready;
  assign rd_last  = (rd_cnt == CNT_MAX);
  assign m_data   = mem[rd_bank][rd_cnt];
  assign m_last   = m_valid && rd_last;

  assign frame_err = frame_err_q;

  // The first beat of a frame latches the mode; later beats reuse it.
  assign mode_eff = (wr_cnt == '0) ? reorder_mode_t'(mode) : mode_q[wr_bank];

  bit_reverse_addr #(.LOG2N(LOG2N)) u_wr_rev (
    .addr (wr_cnt),
    .rev  (wr_rev)
  );

  assign wr_addr = (mode_eff == MODE_BYPASS) ? wr_cnt : wr_rev;

  // Per-bank full flag updates from the write and read sides this cycle.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (s_accept && wr_last) full_set[wr_bank] = 1'b1;
    if (m_accept && rd_last) full_clr[rd_bank] = 1'b1;
  end

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (s_accept) mem[wr_bank][wr_addr] <= s_data;
  end

  // Bank pointers, counters, full flags, per-bank mode and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= '0;
      mode_q[0]   <= MODE_BITREV;
      mode_q[1]   <= MODE_BITREV;
      frame_err_q <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (s_accept) begin
        if (wr_cnt == '0) mode_q[wr_bank] <= reorder_mode_t'(mode);
        if (s_last != wr_last) frame_err_q <= 1'b1;
        wr_cnt <= wr_cnt + CNT_ONE;
        if (wr_last) wr_bank <= !wr_bank;
      end
      if (m_accept) begin
        rd_cnt <= rd_cnt + CNT_ONE;
        if (rd_last) rd_bank <= !rd_bank;
      end
    end
  end

endmodule
